// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures ROM words into an IF/ID register, handles redirect and end-of-image halt.
// Optional misaligned-redirect detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          PROG_WORDS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        misalign_err,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(PROG_WORDS * 4);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_instr_reg, out_pc_reg;
    logic        halted_reg;
    logic [15:0] count_reg;

    logic redirect_take, slot_free, in_range, accept, capture, misaligned;

    // A redirect is ignored only while parked in IDLE with the unit disabled.
    assign redirect_take = redirect_valid && !(state_reg == IDLE && !en);
    assign slot_free     = !out_valid_reg || out_ready;
    assign in_range      = pc_reg < PC_LIMIT;
    assign accept        = out_valid_reg && out_ready;
    assign capture       = (state_reg == RUN) && slot_free && !redirect_valid && in_range;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_reg;

    assign misaligned   = redirect_pc[1:0] != 2'b00;
    assign misalign_err = misalign_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (redirect_take && misaligned) begin
            misalign_reg <= 1'b1;
        end
    end
`else
    logic redirect_lsb_unused;

    assign redirect_lsb_unused = &{1'b0, redirect_pc[1:0]};
    assign misaligned          = 1'b0;
    assign misalign_err        = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (en) state_next = RUN;
            RUN: begin
                if (slot_free && !redirect_valid && !in_range) begin
                    state_next = HALT;
                end else if (!en) begin
                    state_next = IDLE;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
        // Redirect overrides every other transition.
        if (redirect_take) begin
            state_next = misaligned ? HALT : RUN;
        end
    end

    always_comb begin
        pc_next        = pc_reg;
        out_valid_next = out_valid_reg;
        if (redirect_take) begin
            pc_next        = {redirect_pc[31:2], 2'b00};
            out_valid_next = 1'b0;
        end else if (capture) begin
            pc_next        = pc_reg + 32'd4;
            out_valid_next = 1'b1;
        end else if (accept) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pc_reg        <= PC_RESET;
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'h0;
            out_pc_reg    <= 32'h0;
            halted_reg    <= 1'b0;
            count_reg     <= 16'h0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            out_valid_reg <= out_valid_next;
            halted_reg    <= (state_next == HALT);
            if (capture) begin
                out_instr_reg <= imem_instr;
                out_pc_reg    <= pc_reg;
            end
            if (accept) begin
                count_reg <= count_reg + 16'd1;
            end
        end
    end

    assign imem_pc     = pc_reg;
    assign out_valid   = out_valid_reg;
    assign out_instr   = out_instr_reg;
    assign out_pc      = out_pc_reg;
    assign halted      = halted_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight run, halt release, async reset, backpressure, redirect flush, misaligned redirect.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        misalign_err;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.PC_RESET(32'h0000_0000), .PROG_WORDS(7)) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Program image; addresses beyond the image read as zero.
    always_comb begin
        case (imem_pc)
            32'h00:  imem_instr = 32'h5100_0201;
            32'h04:  imem_instr = 32'h6110_0403;
            32'h08:  imem_instr = 32'h7120_0605;
            32'h0C:  imem_instr = 32'h1234_0008;
            32'h10:  imem_instr = 32'h8312_0000;
            32'h14:  imem_instr = 32'h9A0B_0C0D;
            32'h18:  imem_instr = 32'h4512_0000;
            default: imem_instr = 32'h0000_0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s ok   value=%h", tag, obs);
        end else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_count", {16'h0, fetch_count}, 32'h0);
        check("rst_pc", imem_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_misalign", {31'h0, misalign_err}, 32'h0);
        #1 rst = 1'b0;

        // Straight run to the end of the image
        en = 1'b1; out_ready = 1'b1;
        step();
        check("idle2run_vld", {31'h0, out_valid}, 32'h0);
        check("idle2run_pc", imem_pc, 32'h0);
        step();
        check("run_w0_instr", out_instr, 32'h5100_0201);
        check("run_w0_pc", out_pc, 32'h0);
        check("run_w0_vld", {31'h0, out_valid}, 32'h1);
        step();
        check("run_w1_instr", out_instr, 32'h6110_0403);
        check("run_w1_pc", out_pc, 32'h4);
        step(); step(); step();
        check("run_w4_instr", out_instr, 32'h8312_0000);
        check("run_w4_pc", out_pc, 32'h10);
        step(); step();
        check("run_w6_instr", out_instr, 32'h4512_0000);
        check("run_w6_pc", out_pc, 32'h18);
        check("run_w6_count", {16'h0, fetch_count}, 32'd6);
        step();
        check("halt_vld", {31'h0, out_valid}, 32'h0);
        check("halt_halted", {31'h0, halted}, 32'h1);
        check("halt_count", {16'h0, fetch_count}, 32'd7);
        check("halt_pc", imem_pc, 32'h1C);
        step();
        check("halt_hold", {31'h0, halted}, 32'h1);
        check("halt_hold_pc", imem_pc, 32'h1C);

        // Halt release via redirect to 0
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("rel_halted", {31'h0, halted}, 32'h0);
        check("rel_vld", {31'h0, out_valid}, 32'h0);
        check("rel_pc", imem_pc, 32'h0);
        step();
        check("rel_instr", out_instr, 32'h5100_0201);
        check("rel_outpc", out_pc, 32'h0);
        step();
        check("rel_w1_instr", out_instr, 32'h6110_0403);
        check("rel_count", {16'h0, fetch_count}, 32'd8);

        // Asynchronous reset between clock edges with a word pending
        #2 rst = 1'b1;
        #1;
        check("arst_vld", {31'h0, out_valid}, 32'h0);
        check("arst_halted", {31'h0, halted}, 32'h0);
        check("arst_count", {16'h0, fetch_count}, 32'h0);
        check("arst_pc", imem_pc, 32'h0);
        out_ready = 1'b0;
        step();
        #2 rst = 1'b0;

        // Backpressure after the first capture
        step();
        step();
        check("bp_first", out_instr, 32'h5100_0201);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_instr", out_instr, 32'h5100_0201);
            check("bp_hold_pc", imem_pc, 32'h4);
            check("bp_hold_vld", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_instr", out_instr, 32'h6110_0403);
        check("bp_count", {16'h0, fetch_count}, 32'd1);

        // Redirect flush while the word at pc 8 is stalled
        step();
        check("rf_w2_pc", out_pc, 32'h8);
        out_ready = 1'b0;
        step();
        check("rf_hold_pc", out_pc, 32'h8);
        check("rf_hold_cnt", {16'h0, fetch_count}, 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("rf_flush_vld", {31'h0, out_valid}, 32'h0);
        check("rf_flush_pc", imem_pc, 32'h10);
        step();
        check("rf_instr", out_instr, 32'h8312_0000);
        check("rf_outpc", out_pc, 32'h10);
        check("rf_cnt", {16'h0, fetch_count}, 32'd2);
        step();
        check("rf_cnt_after", {16'h0, fetch_count}, 32'd3);

        // Misaligned redirect to 0x12; the pending word is accepted in the same cycle
        redirect_valid = 1'b1; redirect_pc = 32'h12;
        step();
        redirect_valid = 1'b0;
        check("mis_vld", {31'h0, out_valid}, 32'h0);
        check("mis_cnt", {16'h0, fetch_count}, 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_err", {31'h0, misalign_err}, 32'h1);
        check("mis_halted", {31'h0, halted}, 32'h1);
        step();
        check("mis_no_out", {31'h0, out_valid}, 32'h0);
        check("mis_sticky", {31'h0, misalign_err}, 32'h1);
`else
        check("mis_err", {31'h0, misalign_err}, 32'h0);
        check("mis_halted", {31'h0, halted}, 32'h0);
        check("mis_pc", imem_pc, 32'h10);
        step();
        check("mis_instr", out_instr, 32'h8312_0000);
        check("mis_outpc", out_pc, 32'h10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
